// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the controller (master) and the data-memory responder (slave).
// Handshake: a request is taken on any rising edge where Busy=0 and MemRead|MemWrite=1; the result is valid only in the single cycle RespValid=1.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        Busy;
  logic        RespValid;
  logic [31:0] ReadData;
  logic        Error;

  modport master (
    output MemRead, MemWrite, Size, Unsigned, Address, WriteData,
    input  Busy, RespValid, ReadData, Error
  );

  modport slave (
    input  MemRead, MemWrite, Size, Unsigned, Address, WriteData,
    output Busy, RespValid, ReadData, Error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: one outstanding load/store into a little-endian word array,
// with byte/half/word lanes, optional sign extension and error detection on the latched request.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int              IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]      LAT_M1  = 4'(LATENCY - 1);
  localparam logic [31:0]     DEPTH_L = 32'(DEPTH_WORDS);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;

  logic        req_rd;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        s_rd;
  logic        s_wr;
  logic [1:0]  s_size;
  logic        s_uns;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IW-1:0] idx;
  logic [31:0]   word_idx;
  logic          err;
  logic          enter_resp;
  logic          accept;
  logic [31:0]   old_word;
  logic [31:0]   store_word;
  logic [31:0]   load_val;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign accept     = (state == S_IDLE) && (bus.MemRead || bus.MemWrite);
  assign enter_resp = (next_state == S_RESP) && (state != S_RESP);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd1) next_state = S_RESP;
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.Busy      = (state != S_IDLE);
    bus.RespValid = (state == S_RESP);
    dbg_state     = state;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= 4'd0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_size  <= 2'b00;
      req_uns   <= 1'b0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
    end else if (accept) begin
      cnt       <= LAT_M1;
      req_rd    <= bus.MemRead;
      req_wr    <= bus.MemWrite;
      req_size  <= bus.Size;
      req_uns   <= bus.Unsigned;
      req_addr  <= bus.Address;
      req_wdata <= bus.WriteData;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With LATENCY=1 the response edge is the accept edge, so the request comes straight from the bus.
  always_comb begin
    s_rd    = req_rd;
    s_wr    = req_wr;
    s_size  = req_size;
    s_uns   = req_uns;
    s_addr  = req_addr;
    s_wdata = req_wdata;
    if (state == S_IDLE) begin
      s_rd    = bus.MemRead;
      s_wr    = bus.MemWrite;
      s_size  = bus.Size;
      s_uns   = bus.Unsigned;
      s_addr  = bus.Address;
      s_wdata = bus.WriteData;
    end
  end

  assign word_idx = {2'b00, s_addr[31:2]};
  assign idx      = s_addr[IW+1:2];
  assign old_word = mem[idx];

  always_comb begin
    err = 1'b0;
    if (s_rd && s_wr)                             err = 1'b1;
    if (s_size == 2'b11)                          err = 1'b1;
    if ((s_size == 2'b01) && s_addr[0])           err = 1'b1;
    if ((s_size == 2'b10) && (s_addr[1:0] != 2'b00)) err = 1'b1;
    if (word_idx >= DEPTH_L)                      err = 1'b1;
  end

  always_comb begin
    byte_v     = old_word[{s_addr[1:0], 3'b000} +: 8];
    half_v     = old_word[{s_addr[1], 4'b0000} +: 16];
    store_word = old_word;
    load_val   = old_word;
    case (s_size)
      2'b00: begin
        store_word[{s_addr[1:0], 3'b000} +: 8] = s_wdata[7:0];
        load_val = {{24{~s_uns & byte_v[7]}}, byte_v};
      end
      2'b01: begin
        store_word[{s_addr[1], 4'b0000} +: 16] = s_wdata[15:0];
        load_val = {{16{~s_uns & half_v[15]}}, half_v};
      end
      default: begin
        store_word = s_wdata;
        load_val   = old_word;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.ReadData <= 32'd0;
      bus.Error    <= 1'b0;
    end else if (enter_resp) begin
      bus.Error    <= err;
      bus.ReadData <= (err || !s_rd) ? 32'd0 : load_val;
    end
  end

  // Memory is intentionally not reset; a reset edge drops any pending store.
  always_ff @(posedge Clk) begin
    if (!Reset && enter_resp && s_wr && !err) mem[idx] <= store_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed requests feed an expected-response queue that a
// negedge monitor drains; a second LATENCY=1 instance covers back-to-back held requests.
module tb_data_mem_responder;

  localparam int LAT0  = 2;
  localparam int DEPTH = 1024;

  logic clk;
  logic Reset;
  logic [1:0] dbg_state0;
  logic [1:0] dbg_state1;
  int cyc;
  int checks;
  int errors;
  logic [32:0] exp_q[$];
  int          cyc_q[$];
  bit          chk_busy_next;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
    .Clk(clk), .Reset(Reset), .bus(bus0), .dbg_state(dbg_state0)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .Clk(clk), .Reset(Reset), .bus(bus1), .dbg_state(dbg_state1)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic logic [32:0] ok(input logic [31:0] d);
    return {1'b0, d};
  endfunction

  function automatic logic [32:0] bad();
    return {1'b1, 32'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Driver: called at a negedge; returns at the negedge after the accept edge.
  task automatic do_req(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [32:0] exp);
    int n;
    n = 0;
    while (bus0.Busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy %b expected 0", bus0.Busy);
    end
    bus0.MemRead   = rd;
    bus0.MemWrite  = wr;
    bus0.Size      = sz;
    bus0.Unsigned  = uns;
    bus0.Address   = addr;
    bus0.WriteData = wd;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + LAT0);
    @(negedge clk);
    bus0.MemRead  = 1'b0;
    bus0.MemWrite = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [32:0] e;
    int          ec;
    chk_busy_next = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_busy_next) begin
        check("busy_gap", 32'(bus0.Busy), 32'd0);
        chk_busy_next = 1'b0;
      end
      if (bus0.RespValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got RespValid=1 expected 0 at cycle %0d", cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          check("read_data", bus0.ReadData, e[31:0]);
          check("error", 32'(bus0.Error), 32'(e[32]));
          check("resp_cycle", cyc, ec);
          check("busy_in_resp", 32'(bus0.Busy), 32'd1);
        end
        chk_busy_next = 1'b1;
      end
    end
  end

  initial begin
    int n;
    bit exp_b;
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus0.MemRead = 1'b0; bus0.MemWrite = 1'b0; bus0.Size = 2'b00; bus0.Unsigned = 1'b0;
    bus0.Address = 32'd0; bus0.WriteData = 32'd0;
    bus1.MemRead = 1'b0; bus1.MemWrite = 1'b0; bus1.Size = 2'b00; bus1.Unsigned = 1'b0;
    bus1.Address = 32'd0; bus1.WriteData = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus0.Busy), 32'd0);
    check("rst_respvalid", 32'(bus0.RespValid), 32'd0);
    check("rst_readdata", bus0.ReadData, 32'd0);
    check("rst_error", 32'(bus0.Error), 32'd0);
    check("rst_state", 32'(dbg_state0), 32'd0);
    Reset = 1'b0;
    @(negedge clk);

    // Word round trip
    do_req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, ok(32'h0));
    do_req(1, 0, 2'b10, 0, 32'h10, 32'h0,        ok(32'hDEADBEEF));

    // Byte lanes
    do_req(0, 1, 2'b10, 0, 32'h20, 32'h11223344, ok(32'h0));
    do_req(0, 1, 2'b00, 0, 32'h22, 32'h123456AA, ok(32'h0));
    do_req(1, 0, 2'b10, 0, 32'h20, 32'h0, ok(32'h11AA3344));
    do_req(1, 0, 2'b00, 0, 32'h22, 32'h0, ok(32'hFFFFFFAA));
    do_req(1, 0, 2'b00, 1, 32'h22, 32'h0, ok(32'h000000AA));
    do_req(1, 0, 2'b00, 0, 32'h23, 32'h0, ok(32'h00000011));
    do_req(1, 0, 2'b00, 0, 32'h20, 32'h0, ok(32'h00000044));

    // Half lanes
    do_req(0, 1, 2'b10, 0, 32'h30, 32'h7E7E1234, ok(32'h0));
    do_req(0, 1, 2'b01, 0, 32'h32, 32'hABCD8001, ok(32'h0));
    do_req(1, 0, 2'b01, 0, 32'h32, 32'h0, ok(32'hFFFF8001));
    do_req(1, 0, 2'b01, 1, 32'h32, 32'h0, ok(32'h00008001));
    do_req(1, 0, 2'b01, 0, 32'h30, 32'h0, ok(32'h00001234));
    do_req(1, 0, 2'b10, 0, 32'h30, 32'h0, ok(32'h80011234));

    // Error cases
    do_req(1, 0, 2'b10, 0, 32'h13, 32'h0, bad());
    do_req(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, ok(32'h0));
    do_req(0, 1, 2'b01, 0, 32'h41, 32'h0000BEEF, bad());
    do_req(1, 0, 2'b10, 0, 32'h40, 32'h0, ok(32'hCAFEF00D));
    do_req(1, 1, 2'b10, 0, 32'h40, 32'h00000000, bad());
    do_req(1, 0, 2'b10, 0, 32'h40, 32'h0, ok(32'hCAFEF00D));
    do_req(1, 0, 2'b11, 0, 32'h10, 32'h0, bad());
    do_req(0, 1, 2'b10, 0, 32'h0, 32'h0BADF00D, ok(32'h0));
    do_req(0, 1, 2'b10, 0, 32'(4 * DEPTH), 32'hFFFFFFFF, bad());
    do_req(1, 0, 2'b10, 0, 32'(4 * DEPTH), 32'h0, bad());
    do_req(1, 0, 2'b10, 0, 32'h0, 32'h0, ok(32'h0BADF00D));

    // Reset mid-flight
    do_req(0, 1, 2'b10, 0, 32'h50, 32'h12345678, ok(32'h0));
    do_req(1, 0, 2'b10, 0, 32'h50, 32'h0, ok(32'h12345678));
    n = 0;
    while (bus0.Busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus0.MemWrite = 1'b1; bus0.Size = 2'b00; bus0.Address = 32'h50; bus0.WriteData = 32'h55;
    @(negedge clk);
    bus0.MemWrite = 1'b0;
    check("midflight_busy", 32'(bus0.Busy), 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    check("mrst_busy", 32'(bus0.Busy), 32'd0);
    check("mrst_respvalid", 32'(bus0.RespValid), 32'd0);
    check("mrst_readdata", bus0.ReadData, 32'd0);
    check("mrst_error", 32'(bus0.Error), 32'd0);
    check("mrst_state", 32'(dbg_state0), 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    do_req(1, 0, 2'b10, 0, 32'h50, 32'h0, ok(32'h12345678));

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // LATENCY=1 instance with a store held high
    bus1.MemWrite = 1'b1; bus1.Size = 2'b10; bus1.Address = 32'h4; bus1.WriteData = 32'h1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_b = ((i % 2) == 0);
      check("lat1_busy", 32'(bus1.Busy), 32'(exp_b));
      check("lat1_respvalid", 32'(bus1.RespValid), 32'(exp_b));
      if (exp_b) check("lat1_error", 32'(bus1.Error), 32'd0);
    end
    bus1.MemWrite = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
